fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Instruction-fetch stage of the P6 pipeline. It is the producer feeding the IF/ID pipeline register.
- Generates the PC and drives the instruction-memory request/ready handshake.
- Buffers fetched words in a 2-entry queue and presents the head (instruction + PC) to IF/ID.
- Honours the hazard-unit stall and MIPS branch-delay-slot redirect semantics.

Parameters:
- RESET_PC, 32'h00003000, first fetch address after reset.
- IM_BASE, 32'h00003000, lowest legal instruction address.
- IM_WORDS, 4096, number of legal instruction words from IM_BASE.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low (0 = reset).
- stall  input  1  hazard-unit hold. IF/ID takes the queue head only when stall=0.
- redirect_valid  input  1  branch/jump taken in ID. Sampled only when stall=0.
- redirect_pc  input  32  branch/jump target.
- im_req  output  1  memory request.
- im_addr  output  32  request word address.
- im_ready  input  1  memory response strobe. im_rdata is valid in the same cycle.
- im_rdata  input  32  fetched word.
- if_ins  output  32  queue-head instruction. Forced to 0 (nop) when if_valid=0.
- if_pc  output  32  queue-head PC. Holds its last value when if_valid=0.
- if_valid  output  1  queue head is valid.
- if_busy  output  1  queue empty while a request is outstanding (hazard-unit info).
- addr_err  output  1  sticky illegal-fetch-address flag.

Behaviour:
- Reset (async, reset=0):
  - pc_q=RESET_PC, queue empty, pend cleared, state=IDLE.
  - im_req=0, im_addr=RESET_PC.
  - if_valid=0, if_ins=0, if_pc=RESET_PC, if_busy=0, addr_err=0.
- States:
  - IDLE: one cycle after reset release, no request, then → REQ.
  - REQ: im_req=1 and im_addr=pc_q whenever credit allows (see below).
  - DROP: in-flight response is to be discarded. im_req stays 1 with im_addr held. On im_ready the data is discarded and the state goes → REQ.
  - ERR: im_req=0 permanently. Left only by reset.
- Handshake:
  - Once im_req rises, im_req and im_addr hold until the im_ready cycle (no abort).
  - im_ready with im_req=0 is ignored.
  - A transfer is the cycle where im_req=1 and im_ready=1.
  - Zero-wait memory is allowed, i.e. ready in the first request cycle.
- Credit:
  - A new request starts only if (queue occupancy − head consumed this cycle + 1) ≤ 2.
  - An accepted response is never lost.
- Transfer in REQ:
  - The word and pc_q are pushed to the queue tail.
  - pc_q ← pend valid ? pend_pc : pc_q+4, and pend is cleared.
  - The next request may start in the following cycle.
- Consume:
  - When if_valid=1 and stall=0, the head is popped at the clock edge.
- Latency:
  - A transfer at cycle n gives if_valid=1 from cycle n+1 (registered queue).
  - Steady state with zero-wait memory and no stall delivers one instruction per cycle.
  - The first if_valid appears 2 cycles after reset release.
- Redirect (redirect_valid=1 and stall=0). The consumed head is the delay slot.
  - Occupancy ≥1:
    - Keep (consume) the head; flush the second entry.
    - Any in-flight request → DROP. If the transfer happens in the same cycle, discard it.
    - pc_q ← redirect_pc.
  - Occupancy 0:
    - The in-flight or next fetch is the delay slot and is kept.
    - pend_pc ← redirect_pc.
  - redirect_valid while stall=1: ignored.
- Simultaneous events:
  - Redirect beats the sequential +4 update.
  - Reset beats everything.
  - Push and pop in the same cycle leave occupancy unchanged.
- Address check:
  - Applies to pc_q before a request is issued.
  - Illegal if pc_q[1:0]≠0, pc_q<IM_BASE, or pc_q≥IM_BASE+4·IM_WORDS.
  - On an illegal address: no request, addr_err←1, state→ERR.
  - Entries already queued still drain to IF/ID.
- Wrap-around: pc_q+4 is modulo 2^32. Out-of-range results are caught by the address check.
- Reset asserted mid-WAIT: state is cleared immediately and the outstanding response is ignored. The memory must also be reset.
- if_busy = (occupancy==0) and im_req.

Test Plan:
- Release reset; zero-wait memory returns im_rdata=addr → if_valid first high 2 cycles after release; if_pc 0x3000, 0x3004, 0x3008 on consecutive cycles, if_ins equal to if_pc.
- stall=1 for 3 cycles during streaming → queue fills to 2, im_req falls to 0 with no further requests, if_pc held; after release, deliveries continue with no PC skipped or repeated.
- Head 0x3008 valid, redirect 0x3100 with stall=0 → 0x3008 consumed; next delivered if_pc=0x3100; 0x300C never presented.
- Queue empty, request 0x3004 waiting 2 wait states, redirect 0x3200 → 0x3004 delivered (delay slot), then 0x3200; if_busy=1 during the wait.
- Redirect while a wrong-path request is in wait states → DROP; im_addr held until im_ready; that data is never presented; next request address = target.
- Redirect to 0x3102 → addr_err=1, im_req=0 thereafter, queue drains; asserting reset=0 mid-fetch clears all outputs immediately to reset values.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: generates the PC, runs the imem req/ready handshake and queues fetched words for IF/ID.
// Latency: a transfer in cycle n is presented on if_* in cycle n+1; the first valid comes 2 cycles after reset release.
// Backpressure: stall holds the queue head; a request is only issued when the 2-entry queue has room for its response.
//
// Ports:
//   clk, reset (async, active-low)    clock and reset
//   stall, redirect_valid/pc          hazard-unit hold and taken branch/jump from ID (delay-slot semantics)
//   im_req/im_addr/im_ready/im_rdata  instruction-memory handshake; a transfer is im_req & im_ready
//   if_ins/if_pc/if_valid             queue head presented to IF/ID (if_ins is a nop when not valid)
//   if_busy, addr_err                 empty-but-waiting indication, sticky illegal-address flag
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ready,
  input  logic [31:0] im_rdata,
  output logic [31:0] if_ins,
  output logic [31:0] if_pc,
  output logic        if_valid,
  output logic        if_busy,
  output logic        addr_err
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP, S_ERR} state_t;

  // One past the last legal byte address; 33 bits so the top of the space cannot wrap.
  localparam logic [32:0] IM_LIMIT = {1'b0, IM_BASE} + (33'(IM_WORDS) << 2);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_vld_q, pend_vld_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        req_act_q, req_act_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic [1:0]  occ_q, occ_d;
  logic [31:0] q_ins_q [2];
  logic [31:0] q_ins_d [2];
  logic [31:0] q_pc_q [2];
  logic [31:0] q_pc_d [2];
  logic [31:0] last_pc_q, last_pc_d;
  logic        err_q, err_d;

  logic pop, redir, flush, redir_empty;
  logic addr_ok, credit_ok, start_req, xfer, keep;

  // Handshake, credit and output decode.
  always_comb begin
    if_valid    = (occ_q != 2'd0);
    pop         = if_valid && !stall;
    redir       = redirect_valid && !stall;
    // A redirect that consumes a head makes that head the delay slot: everything behind it is wrong-path.
    flush       = redir && if_valid;
    // With nothing queued, the next word to arrive is the delay slot; the target is parked in pend.
    redir_empty = redir && !if_valid;

    addr_ok   = (pc_q[1:0] == 2'b00) && (pc_q >= IM_BASE) && ({1'b0, pc_q} < IM_LIMIT);
    credit_ok = (occ_q - {1'b0, pop}) <= 2'd1;

    // A new request never starts in a flush cycle, so it cannot be for a wrong-path address.
    start_req = (state_q == S_REQ) && !req_act_q && credit_ok && addr_ok && !flush;
    im_req    = req_act_q || start_req;
    im_addr   = req_act_q ? req_addr_q : pc_q;
    xfer      = im_req && im_ready;
    keep      = xfer && (state_q == S_REQ) && !flush;

    if_ins   = if_valid ? q_ins_q[0] : 32'd0;
    if_pc    = if_valid ? q_pc_q[0] : last_pc_q;
    if_busy  = !if_valid && im_req;
    addr_err = err_q;
  end

  // Next-state, PC and queue update.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_vld_d = pend_vld_q;
    pend_pc_d  = pend_pc_q;
    req_act_d  = im_req && !im_ready;
    req_addr_d = im_addr;
    err_d      = err_q;
    last_pc_d  = if_pc;
    occ_d      = occ_q;
    q_ins_d    = q_ins_q;
    q_pc_d     = q_pc_q;

    case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (!req_act_q && !addr_ok && !flush) begin
          state_d = S_ERR;
          err_d   = 1'b1;
        end else if (flush && im_req && !im_ready) begin
          // Wrong-path request already on the bus: it must complete, then be thrown away.
          state_d = S_DROP;
        end
      end
      S_DROP: if (im_ready) state_d = S_REQ;
      S_ERR:  state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      pc_d       = redirect_pc;
      pend_vld_d = 1'b0;
    end else if (keep) begin
      // A redirect arriving with the delay slot itself beats both pend and the sequential +4.
      if (redir_empty)     pc_d = redirect_pc;
      else if (pend_vld_q) pc_d = pend_pc_q;
      else                 pc_d = pc_q + 32'd4;
      pend_vld_d = 1'b0;
    end else if (redir_empty) begin
      pend_vld_d = 1'b1;
      pend_pc_d  = redirect_pc;
    end

    if (flush) begin
      occ_d = 2'd0;
    end else begin
      if (pop) begin
        q_ins_d[0] = q_ins_q[1];
        q_pc_d[0]  = q_pc_q[1];
        occ_d      = occ_q - 2'd1;
      end
      // Credit guarantees occ_d is 0 or 1 here.
      if (keep) begin
        q_ins_d[occ_d[0]] = im_rdata;
        q_pc_d[occ_d[0]]  = im_addr;
        occ_d             = occ_d + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      pc_q       <= RESET_PC;
      pend_vld_q <= 1'b0;
      pend_pc_q  <= 32'd0;
      req_act_q  <= 1'b0;
      req_addr_q <= RESET_PC;
      occ_q      <= 2'd0;
      q_ins_q[0] <= 32'd0;
      q_ins_q[1] <= 32'd0;
      q_pc_q[0]  <= 32'd0;
      q_pc_q[1]  <= 32'd0;
      last_pc_q  <= RESET_PC;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_vld_q <= pend_vld_d;
      pend_pc_q  <= pend_pc_d;
      req_act_q  <= req_act_d;
      req_addr_q <= req_addr_d;
      occ_q      <= occ_d;
      q_ins_q    <= q_ins_d;
      q_pc_q     <= q_pc_d;
      last_pc_q  <= last_pc_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by randomized stall/redirect/wait-state traffic.
// Expected instruction order comes from a program-order model with branch delay slots.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        reset, stall, redirect_valid, im_ready;
  logic [31:0] redirect_pc, im_rdata;
  logic        im_req, if_valid, if_busy, addr_err;
  logic [31:0] im_addr, if_ins, if_pc;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .im_req(im_req), .im_addr(im_addr), .im_ready(im_ready), .im_rdata(im_rdata),
    .if_ins(if_ins), .if_pc(if_pc), .if_valid(if_valid), .if_busy(if_busy), .addr_err(addr_err)
  );

  int total = 0;
  int bad = 0;

  // Memory model
  logic [31:0] hash_key = 32'd0;
  int          wait_mode = 0;   // <0: random 0..2 wait states
  bit          noise_en = 1'b0;
  bit          mem_busy = 1'b0;
  int          mem_wait = 0;
  logic [31:0] mem_addr = 32'd0;

  // Program-order model
  logic [31:0] exp_next = 32'h3000;
  bit          pend_has = 1'b0;
  logic [31:0] pend_tgt = 32'd0;
  bit          err_phase = 1'b0;
  int          n_consumed = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ hash_key;
  endfunction

  function automatic logic legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= 32'h3000) && (a < 32'h7000);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_im_req"}, im_req, 0);
    check({tag, "_im_addr"}, im_addr, 32'h3000);
    check({tag, "_if_valid"}, if_valid, 0);
    check({tag, "_if_ins"}, if_ins, 0);
    check({tag, "_if_pc"}, if_pc, 32'h3000);
    check({tag, "_if_busy"}, if_busy, 0);
    check({tag, "_addr_err"}, addr_err, 0);
  endtask

  // One clock cycle. Called at the falling edge with stall/redirect already set.
  task automatic tick();
    logic xfer;
    #1;
    if (mem_busy) begin
      check("req_hold", im_req, 1);
      check("addr_hold", im_addr, mem_addr);
    end else if (im_req) begin
      mem_busy = 1'b1;
      mem_addr = im_addr;
      mem_wait = (wait_mode < 0) ? int'($urandom_range(0, 2)) : wait_mode;
      check("req_addr_legal", legal(im_addr), 1);
    end
    if (mem_busy) begin
      im_ready = (mem_wait == 0);
      im_rdata = im_ready ? mem_word(mem_addr) : $urandom;
    end else begin
      im_ready = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
      im_rdata = $urandom;
    end
    #1;
    check("if_busy", if_busy, !if_valid && im_req);
    if (!if_valid) check("nop_ins", if_ins, 0);
    else           check("ins_matches_pc", if_ins, mem_word(if_pc));
    if (!err_phase) check("no_addr_err", addr_err, 0);
    if (if_valid && !stall) begin
      check("seq_pc", if_pc, exp_next);
      n_consumed++;
    end
    if (redirect_valid && !stall) begin
      if (if_valid) begin
        exp_next = redirect_pc;
        pend_has = 1'b0;
      end else begin
        pend_has = 1'b1;
        pend_tgt = redirect_pc;
      end
    end else if (if_valid && !stall) begin
      exp_next = pend_has ? pend_tgt : if_pc + 32'd4;
      pend_has = 1'b0;
    end
    xfer = im_req && im_ready;
    @(posedge clk);
    if (xfer) mem_busy = 1'b0;
    else if (mem_busy) mem_wait--;
    @(negedge clk);
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!if_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_valid_timeout"}, if_valid, 1);
  endtask

  task automatic wait_empty_req(input string tag);
    int n = 0;
    while (!(!if_valid && im_req) && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_empty_req_timeout"}, !if_valid && im_req, 1);
  endtask

  task automatic do_reset();
    reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    im_ready = 1'b0; im_rdata = 32'd0;
    mem_busy = 1'b0; exp_next = 32'h3000; pend_has = 1'b0; err_phase = 1'b0;
    @(negedge clk);
    #1;
    check_reset_vals("rst");
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("idle_no_req", im_req, 0);
    check("idle_no_valid", if_valid, 0);
  endtask

  initial begin
    logic [31:0] ds, drop_addr;
    int n0, n;

    // Zero-wait streaming from reset, rdata = addr.
    hash_key = 32'd0; wait_mode = 0; noise_en = 1'b0;
    do_reset();
    tick();
    check("first_req", im_req, 1);
    check("first_addr", im_addr, 32'h3000);
    check("first_busy", if_busy, 1);
    check("first_not_valid", if_valid, 0);
    tick();
    check("first_valid", if_valid, 1);
    check("pc0", if_pc, 32'h3000);
    check("ins0", if_ins, 32'h3000);
    tick();
    check("pc1", if_pc, 32'h3004);
    tick();
    check("pc2", if_pc, 32'h3008);

    // Stall: queue fills to two, requests stop, head holds.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    check("stall_pc_held", if_pc, 32'h3008);
    check("stall_no_req", im_req, 0);
    check("stall_valid", if_valid, 1);

    // Redirect on head 0x3008: it is the delay slot, 0x300C is flushed.
    stall = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h3100;
    tick();
    redirect_valid = 1'b0;
    wait_mode = 2;
    wait_valid("redir");
    check("redir_target", if_pc, 32'h3100);

    // Empty queue, request in wait states, redirect: in-flight word is the delay slot.
    wait_empty_req("ds");
    check("ds_busy", if_busy, 1);
    ds = im_addr;
    redirect_valid = 1'b1; redirect_pc = 32'h3200;
    tick();
    redirect_valid = 1'b0;
    check("ds_busy_wait", if_busy, 1);
    wait_valid("ds");
    check("ds_delivered", if_pc, ds);
    tick();
    wait_valid("ds_tgt");
    check("ds_target", if_pc, 32'h3200);

    // Wrong-path request already on the bus: DROP holds it, then discards it.
    stall = 1'b1;
    tick();
    stall = 1'b0;
    drop_addr = im_addr;
    check("drop_inflight", im_req, 1);
    redirect_valid = 1'b1; redirect_pc = 32'h3300;
    tick();
    redirect_valid = 1'b0;
    check("drop_req_held", im_req, 1);
    check("drop_addr_held", im_addr, drop_addr);
    check("drop_queue_empty", if_valid, 0);
    tick();
    check("drop_next_req", im_req, 1);
    check("drop_next_addr", im_addr, 32'h3300);
    wait_valid("drop");
    check("drop_target", if_pc, 32'h3300);

    // Randomized traffic.
    do_reset();
    hash_key = 32'h5A5A_A5A5; wait_mode = -1; noise_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      stall          = ($urandom_range(0, 99) < 30);
      redirect_valid = ($urandom_range(0, 99) < 12);
      redirect_pc    = 32'h3000 + (32'($urandom_range(0, 3000)) << 2);
      tick();
    end
    stall = 1'b0; redirect_valid = 1'b0;
    n0 = n_consumed;
    repeat (30) tick();
    check("drain_progress", (n_consumed - n0) >= 5, 1);

    // Redirect to a misaligned target: queued delay slot still drains, fetching stops.
    wait_mode = 2; noise_en = 1'b0;
    wait_empty_req("err");
    ds = im_addr;
    redirect_valid = 1'b1; redirect_pc = 32'h3102;
    tick();
    redirect_valid = 1'b0; stall = 1'b1; err_phase = 1'b1;
    n = 0;
    while (!addr_err && n < 20) begin
      tick();
      n++;
    end
    check("err_flag", addr_err, 1);
    check("err_no_req", im_req, 0);
    check("err_ds_queued", if_valid, 1);
    check("err_ds_pc", if_pc, ds);
    stall = 1'b0;
    tick();
    check("err_drained", if_valid, 0);
    repeat (5) tick();
    check("err_still_no_req", im_req, 0);
    check("err_sticky", addr_err, 1);

    // Reset asserted in the middle of a waiting fetch.
    do_reset();
    hash_key = 32'd0;
    tick();
    tick();
    check("midrst_req_out", im_req, 1);
    #2;
    reset = 1'b0;
    mem_busy = 1'b0;
    #1;
    check_reset_vals("midrst");
    @(negedge clk);
    reset = 1'b1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
